// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, APB SETUP/ACCESS out, valid/ready response back.
// Optional ACCESS timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    // Both ports use the same handshake: a beat transfers on the rising edge where valid && ready;
    // the producer holds valid and payload steady until then, the consumer may drive ready freely.
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PSELx,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  w_cmd_fire;
    logic                  w_access_done;
    logic                  w_timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_to_cnt;

    // Counts stalled ACCESS cycles; expiry is the stalled cycle that would make the count TIMEOUT_CYCLES.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_ACCESS && !PREADY && r_to_cnt != 16'hFFFF) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == ST_ACCESS) && !PREADY && (r_to_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    assign o_cmd_ready   = (r_state == ST_IDLE) && !i_reset;
    assign w_cmd_fire    = i_cmd_valid && o_cmd_ready;
    assign w_access_done = (r_state == ST_ACCESS) && (PREADY || w_timeout);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_cmd_fire)    w_next_state = ST_SETUP;
            ST_SETUP:                     w_next_state = ST_ACCESS;
            ST_ACCESS: if (w_access_done) w_next_state = ST_RESP;
            ST_RESP:   if (i_rsp_ready)   w_next_state = ST_IDLE;
            default:                      w_next_state = ST_IDLE;
        endcase
    end

    // Request fields load only on acceptance, so they stay frozen for SETUP and every ACCESS cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
        end else if (w_cmd_fire) begin
            r_paddr  <= i_cmd_addr;
            r_pwrite <= i_cmd_write;
            r_pwdata <= i_cmd_wdata;
        end
    end

    // Completion without PREADY can only be a timeout: report an error with zero data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_access_done) begin
            r_rsp_rdata <= (PREADY && !r_pwrite) ? PRDATA : '0;
            r_rsp_err   <= PREADY ? PSLVERR : 1'b1;
        end
    end

    assign PADDR       = r_paddr;
    assign PWRITE      = r_pwrite;
    assign PWDATA      = r_pwdata;
    assign PSELx       = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign PENABLE     = (r_state == ST_ACCESS);
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_dbg_state = r_state;

    a_req_stable: assert property (@(posedge i_clk) disable iff (i_reset)
        (r_state == ST_ACCESS) |-> ($stable(r_paddr) && $stable(r_pwrite) && $stable(r_pwdata)));

    a_setup_once: assert property (@(posedge i_clk) disable iff (i_reset)
        (r_state == ST_SETUP) |=> (r_state == ST_ACCESS));

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: vector table driven through a transaction task, with an {err, rdata} scoreboard
// and hand-written sequences for reset mid-transfer and ACCESS timeout.
module tb_apb_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int NV = 12;

    logic          clk = 1'b0;
    logic          i_reset, i_cmd_valid, i_cmd_write, i_rsp_ready;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_wdata;
    logic          o_cmd_ready, o_rsp_valid, o_rsp_err;
    logic [DW-1:0] o_rsp_rdata;
    logic [AW-1:0] PADDR;
    logic          PWRITE, PSELx, PENABLE, PREADY, PSLVERR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic [1:0]    o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic          slverr;
        int            rsp_delay;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t          vecs[NV];
    logic [DW:0]   exp_q[$];

    always #5 clk = ~clk;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSELx(PSELx), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .o_dbg_state(o_dbg_state)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Junk on the command port while busy; the DUT must ignore it.
    task automatic cmd_noise();
        i_cmd_valid = 1'b1;
        i_cmd_write = 1'($urandom_range(0, 1));
        i_cmd_addr  = $urandom;
        i_cmd_wdata = $urandom;
    endtask

    task automatic run_txn(input vec_t v);
        logic [DW:0] e;
        @(negedge clk);
        chk("idle_state", o_dbg_state, 2'd0);
        chk("idle_cmd_ready", o_cmd_ready, 1'b1);
        chk("idle_psel", PSELx, 1'b0);
        PREADY      = 1'b0;
        i_cmd_valid = 1'b1;
        i_cmd_write = v.write;
        i_cmd_addr  = v.addr;
        i_cmd_wdata = v.wdata;
        exp_q.push_back({v.exp_err, v.exp_rdata});

        @(negedge clk);
        cmd_noise();
        chk("setup_state", o_dbg_state, 2'd1);
        chk("setup_psel", PSELx, 1'b1);
        chk("setup_penable", PENABLE, 1'b0);
        chk("setup_cmd_ready", o_cmd_ready, 1'b0);
        chk("setup_paddr", PADDR, v.addr);
        chk("setup_pwrite", PWRITE, v.write);
        chk("setup_pwdata", PWDATA, v.wdata);
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = $urandom;

        for (int k = 0; k <= v.waits; k++) begin
            @(negedge clk);
            cmd_noise();
            chk("access_state", o_dbg_state, 2'd2);
            chk("access_psel", PSELx, 1'b1);
            chk("access_penable", PENABLE, 1'b1);
            chk("access_rsp_valid", o_rsp_valid, 1'b0);
            chk("access_paddr", PADDR, v.addr);
            chk("access_pwdata", PWDATA, v.wdata);
            chk("access_pwrite", PWRITE, v.write);
            if (k == v.waits) begin
                PREADY  = 1'b1;
                PRDATA  = v.prdata;
                PSLVERR = v.slverr;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end
        end

        for (int d = 0; d <= v.rsp_delay; d++) begin
            @(negedge clk);
            cmd_noise();
            PREADY = 1'($urandom_range(0, 1));
            PRDATA = $urandom;
            chk("resp_state", o_dbg_state, 2'd3);
            chk("resp_valid", o_rsp_valid, 1'b1);
            chk("resp_psel", PSELx, 1'b0);
            chk("resp_penable", PENABLE, 1'b0);
            chk("resp_cmd_ready", o_cmd_ready, 1'b0);
            chk("resp_hold_rdata", o_rsp_rdata, exp_q[0][DW-1:0]);
            chk("resp_hold_err", o_rsp_err, exp_q[0][DW]);
            i_rsp_ready = (d == v.rsp_delay);
        end
        e = exp_q.pop_front();
        chk("rsp_rdata", o_rsp_rdata, e[DW-1:0]);
        chk("rsp_err", o_rsp_err, e[DW]);

        @(negedge clk);
        i_rsp_ready = 1'b0;
        i_cmd_valid = 1'b0;
        PREADY      = 1'b0;
        chk("post_rsp_valid", o_rsp_valid, 1'b0);
        chk("post_state", o_dbg_state, 2'd0);
        chk("post_cmd_ready", o_cmd_ready, 1'b1);
    endtask

    function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd, input int wt,
                                input logic [DW-1:0] rd, input logic se, input int dl);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.waits = wt;
        v.prdata = rd; v.slverr = se; v.rsp_delay = dl;
        v.exp_rdata = w ? '0 : rd;
        v.exp_err   = se;
        return v;
    endfunction

    initial begin
        vec_t vt;
        int   cnt;
        i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0;
        i_rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", o_cmd_ready, 1'b0);
        chk("rst_rsp_valid", o_rsp_valid, 1'b0);
        chk("rst_rsp_rdata", o_rsp_rdata, '0);
        chk("rst_rsp_err", o_rsp_err, 1'b0);
        chk("rst_psel", PSELx, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_paddr", PADDR, '0);
        chk("rst_pwrite", PWRITE, 1'b0);
        chk("rst_pwdata", PWDATA, '0);
        chk("rst_state", o_dbg_state, 2'd0);
        i_reset = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", o_cmd_ready, 1'b1);

        vecs[0] = mk(1'b1, 32'd3, 32'hDEADBEEF, 0, 32'hCAFEF00D, 1'b0, 0);
        vecs[1] = mk(1'b0, 32'd5, 32'h0, 3, 32'h12345678, 1'b0, 0);
        vecs[2] = mk(1'b0, 32'd9, 32'h0, 0, 32'hA5A5A5A5, 1'b1, 0);
        vecs[3] = mk(1'b1, 32'd0, 32'h00000011, 1, 32'h5A5A5A5A, 1'b0, 5);
        vecs[4] = mk(1'b1, 32'hFFFF_FFFC, 32'hFFFFFFFF, 2, 32'h87654321, 1'b1, 1);
        vecs[5] = mk(1'b0, 32'h100, 32'hABCDEF01, 2, 32'hFFFFFFFF, 1'b0, 2);
        for (int i = 6; i < NV; i++) begin
            vecs[i] = mk(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, TO - 1),
                         $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        for (int i = 0; i < NV; i++) run_txn(vecs[i]);

        // Reset in the second ACCESS cycle abandons the transfer.
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 32'h77; i_cmd_wdata = '0;
        exp_q.push_back({1'b0, 32'h0});
        @(negedge clk);
        i_cmd_valid = 1'b0;
        @(negedge clk);
        PREADY = 1'b0;
        @(negedge clk);
        chk("rstmid_in_access", o_dbg_state, 2'd2);
        i_reset = 1'b1; PREADY = 1'b1; PRDATA = 32'h0BAD0BAD;
        @(negedge clk);
        chk("rstmid_psel", PSELx, 1'b0);
        chk("rstmid_penable", PENABLE, 1'b0);
        chk("rstmid_rsp_valid", o_rsp_valid, 1'b0);
        chk("rstmid_state", o_dbg_state, 2'd0);
        chk("rstmid_rdata", o_rsp_rdata, '0);
        exp_q.delete();
        i_reset = 1'b0; PREADY = 1'b0;
        @(negedge clk);
        chk("rstmid_ready_back", o_cmd_ready, 1'b1);
        run_txn(mk(1'b0, 32'h44, 32'h0, 1, 32'h600DF00D, 1'b0, 0));

`ifdef APB_MASTER_TIMEOUT_EN
        // PREADY never rises: terminate after TO ACCESS cycles with an error.
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 32'h40; i_cmd_wdata = '0;
        @(negedge clk);
        i_cmd_valid = 1'b0; PREADY = 1'b0; PRDATA = 32'hFEEDFACE;
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!PENABLE) break;
            cnt++;
        end
        chk("to_penable_cycles", cnt, TO);
        chk("to_rsp_valid", o_rsp_valid, 1'b1);
        chk("to_rsp_err", o_rsp_err, 1'b1);
        chk("to_rsp_rdata", o_rsp_rdata, '0);
        i_rsp_ready = 1'b1;
        @(negedge clk);
        i_rsp_ready = 1'b0;
        chk("to_post_state", o_dbg_state, 2'd0);
`else
        // No timeout: a 100-cycle stall stays in ACCESS and then completes normally.
        vt = mk(1'b0, 32'h40, 32'h0, 100, 32'h13579BDF, 1'b0, 0);
        run_txn(vt);
        cnt = 0;
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
